text_ram_writer: RTL and testbench

//   Writer side of the labels RAM. The vgaModule readers share that RAM and only read it; they

---
 rtl/text_ram_writer_pkg.sv | 12 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/text_ram_writer.sv | 126 ++++++++++++
 tb/tb_text_ram_writer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/text_ram_writer_pkg.sv
// text_ram_writer_pkg: control codes and FSM state type shared by the text RAM writer.
package text_ram_writer_pkg;

    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LAST  = 8'h7E;

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} writerState_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count-based full/empty flags.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  px_clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wrPtr;
    logic [PW-1:0]         rdPtr;
    logic [PW:0]           count;
    logic                  doPush;
    logic                  doPop;

    assign full   = count == (PW+1)'(DEPTH);
    assign empty  = count == '0;
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign dout   = mem[rdPtr];

    always_ff @(posedge px_clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= doPush ? wrPtr + PW'(1) : wrPtr;
            rdPtr <= doPop ? rdPtr + PW'(1) : rdPtr;
            count <= count + (doPush ? (PW+1)'(1) : '0) - (doPop ? (PW+1)'(1) : '0);
        end
    end

endmodule

// File: rtl/text_ram_writer.sv
// text_ram_writer: queues a byte stream and writes it into a text window of the labels RAM during blanking.
module text_ram_writer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int BASE       = 0,
    parameter int LEN        = 28,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  px_clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  activevideo,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_write_en,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] cursor,
    output logic                  busy
);

    import text_ram_writer_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(BASE);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(BASE + LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] D_BS    = DATA_WIDTH'(CHAR_BS);
    localparam logic [DATA_WIDTH-1:0] D_FF    = DATA_WIDTH'(CHAR_FF);
    localparam logic [DATA_WIDTH-1:0] D_CR    = DATA_WIDTH'(CHAR_CR);
    localparam logic [DATA_WIDTH-1:0] D_SPACE = DATA_WIDTH'(CHAR_SPACE);
    localparam logic [DATA_WIDTH-1:0] D_LAST  = DATA_WIDTH'(CHAR_LAST);

    writerState_t          state;
    logic [DATA_WIDTH-1:0] cmd;
    logic [DATA_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] clrPtr;
    logic [ADDR_WIDTH-1:0] cursorDec;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic [DATA_WIDTH-1:0] wrData;
    logic                  readyReg;
    logic                  full;
    logic                  empty;
    logic                  doPop;
    logic                  isPrint;
    logic                  isBs;
    logic                  isCr;
    logic                  isFf;
    logic                  needWr;
    logic                  wrEn;

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .px_clk (px_clk),
        .rstn   (rstn),
        .push   (in_valid && in_ready),
        .pop    (doPop),
        .din    (in_data),
        .dout   (head),
        .full   (full),
        .empty  (empty)
    );

    assign in_ready = readyReg && !full;
    assign busy     = !empty || state != IDLE;
    assign doPop    = state == IDLE && !empty && !activevideo;

    assign isPrint   = cmd >= D_SPACE && cmd <= D_LAST;
    assign isBs      = cmd == D_BS;
    assign isCr      = cmd == D_CR;
    assign isFf      = cmd == D_FF;
    assign cursorDec = cursor - ONE;
    // Backspace at the window start saturates without touching the RAM.
    assign needWr    = isPrint || (isBs && cursor != FIRST);

    // The strobe is gated by activevideo combinationally so a write never overlaps a reader cycle.
    always_comb begin
        wrEn     = rstn && !activevideo && (state == CLEAR || (state == EXEC && needWr));
        wrAddr   = state == CLEAR ? clrPtr : isBs ? cursorDec : cursor;
        wrData   = (state == CLEAR || isBs) ? D_SPACE : cmd;
        ram_write_en = wrEn;
        ram_addr = wrEn ? wrAddr : '0;
        ram_din  = wrEn ? wrData : '0;
    end

    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cmd      <= '0;
            cursor   <= FIRST;
            clrPtr   <= FIRST;
            readyReg <= 1'b0;
        end else begin
            readyReg <= 1'b1;
            case (state)
                IDLE: begin
                    if (doPop) begin
                        cmd   <= head;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (isFf) begin
                        clrPtr <= FIRST;
                        state  <= CLEAR;
                    end else if (isCr) begin
                        cursor <= FIRST;
                        state  <= IDLE;
                    end else if (!needWr) begin
                        state <= IDLE;
                    end else if (!activevideo) begin
                        cursor <= isBs ? cursorDec : cursor == LAST ? FIRST : cursor + ONE;
                        state  <= IDLE;
                    end
                end
                CLEAR: begin
                    if (!activevideo) begin
                        clrPtr <= clrPtr + ONE;
                        cursor <= clrPtr == LAST ? FIRST : cursor;
                        state  <= clrPtr == LAST ? IDLE : CLEAR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_ram_writer.sv
// tb_text_ram_writer: directed vector table plus hand-written multi-cycle sequences for text_ram_writer.
module tb_text_ram_writer;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int BASE = 3;
    localparam int LEN  = 28;
    localparam int NV   = 15;

    logic          px_clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          activevideo = 1'b0;
    logic          in_ready;
    logic [AW-1:0] ram_addr;
    logic          ram_write_en;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] cursor;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit toggling = 0;
    logic [15:0] wq[$];

    typedef struct {
        logic [7:0] data;
        int         nWr;
        logic [7:0] addr;
        logic [7:0] din;
        logic [7:0] cur;
    } vec_t;

    vec_t vecs[NV];

    text_ram_writer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE(BASE), .LEN(LEN), .FIFO_DEPTH(4)
    ) dut (
        .px_clk       (px_clk),
        .rstn         (rstn),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .activevideo  (activevideo),
        .ram_addr     (ram_addr),
        .ram_write_en (ram_write_en),
        .ram_din      (ram_din),
        .cursor       (cursor),
        .busy         (busy)
    );

    always #5 px_clk = ~px_clk;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    always @(negedge px_clk) begin
        if (ram_write_en) wq.push_back({ram_addr, ram_din});
        check("write_during_video", int'(ram_write_en && activevideo), 0);
        check("idle_bus_nonzero", int'(!ram_write_en && (ram_addr != '0 || ram_din != '0)), 0);
    end

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic pushByte(input logic [7:0] b);
        bit done = 0;
        in_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic waitIdle();
        bit ok = 0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            if (!busy) ok = 1;
            else tick();
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    initial forever begin
        tick();
        if (toggling) activevideo = ~activevideo;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'h48, 1, 8'd3, 8'h48, 8'd4};
        vecs[1]  = '{8'h49, 1, 8'd4, 8'h49, 8'd5};
        vecs[2]  = '{8'h01, 0, 8'd0, 8'h00, 8'd5};
        vecs[3]  = '{8'h7F, 0, 8'd0, 8'h00, 8'd5};
        vecs[4]  = '{8'h7E, 1, 8'd5, 8'h7E, 8'd6};
        vecs[5]  = '{8'h20, 1, 8'd6, 8'h20, 8'd7};
        vecs[6]  = '{8'h08, 1, 8'd6, 8'h20, 8'd6};
        vecs[7]  = '{8'h0D, 0, 8'd0, 8'h00, 8'd3};
        vecs[8]  = '{8'h08, 0, 8'd0, 8'h00, 8'd3};
        vecs[9]  = '{8'h61, 1, 8'd3, 8'h61, 8'd4};
        vecs[10] = '{8'h62, 1, 8'd4, 8'h62, 8'd5};
        vecs[11] = '{8'h63, 1, 8'd5, 8'h63, 8'd6};
        vecs[12] = '{8'h08, 1, 8'd5, 8'h20, 8'd5};
        vecs[13] = '{8'h1F, 0, 8'd0, 8'h00, 8'd5};
        vecs[14] = '{8'h0D, 0, 8'd0, 8'h00, 8'd3};

        repeat (3) tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_write_en", int'(ram_write_en), 0);
        check("rst_addr", int'(ram_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cursor", int'(cursor), BASE);
        rstn = 1'b1;
        tick();
        check("post_rst_ready", int'(in_ready), 1);

        for (int i = 0; i < NV; i++) begin
            wq.delete();
            pushByte(vecs[i].data);
            waitIdle();
            check($sformatf("v%0d_nwr", i), wq.size(), vecs[i].nWr);
            if (vecs[i].nWr == 1 && wq.size() == 1) begin
                check($sformatf("v%0d_addr", i), int'(wq[0][15:8]), int'(vecs[i].addr));
                check($sformatf("v%0d_din", i), int'(wq[0][7:0]), int'(vecs[i].din));
            end
            check($sformatf("v%0d_cursor", i), int'(cursor), int'(vecs[i].cur));
        end

        wq.delete();
        activevideo = 1'b1;
        pushByte(8'h41);
        repeat (100) tick();
        check("av_hold_nwr", wq.size(), 0);
        check("av_hold_busy", int'(busy), 1);
        activevideo = 1'b0;
        waitIdle();
        check("av_release_nwr", wq.size(), 1);
        if (wq.size() == 1) check("av_release_entry", int'(wq[0]), {8'd3, 8'h41});
        check("av_release_cursor", int'(cursor), 4);

        pushByte(8'h0D);
        waitIdle();
        wq.delete();
        pushByte(8'h5A);
        check("lat_n1_we", int'(ram_write_en), 0);
        tick();
        check("lat_n2_we", int'(ram_write_en), 1);
        check("lat_n2_addr", int'(ram_addr), BASE);
        check("lat_n2_din", int'(ram_din), 8'h5A);
        waitIdle();
        check("lat_cursor", int'(cursor), BASE + 1);

        pushByte(8'h0D);
        waitIdle();
        wq.delete();
        for (int i = 0; i < LEN + 1; i++) pushByte(8'h78);
        waitIdle();
        check("wrap_nwr", wq.size(), LEN + 1);
        if (wq.size() == LEN + 1) begin
            check("wrap_first", int'(wq[0][15:8]), BASE);
            check("wrap_end", int'(wq[LEN-1][15:8]), BASE + LEN - 1);
            check("wrap_last", int'(wq[LEN]), {8'(BASE), 8'h78});
        end
        check("wrap_cursor", int'(cursor), BASE + 1);

        wq.delete();
        toggling = 1;
        pushByte(8'h0C);
        repeat (4) pushByte(8'h01);
        check("clear_ready_full", int'(in_ready), 0);
        check("clear_busy", int'(busy), 1);
        waitIdle();
        toggling = 0;
        tick();
        activevideo = 1'b0;
        check("clear_nwr", wq.size(), LEN);
        begin
            int bad = 0;
            for (int i = 0; i < wq.size(); i++)
                if (wq[i] != {8'(BASE + i), 8'h20}) bad++;
            check("clear_pattern_bad", bad, 0);
        end
        check("clear_cursor", int'(cursor), BASE);

        pushByte(8'h6B);
        pushByte(8'h6D);
        waitIdle();
        check("pre_abort_cursor", int'(cursor), BASE + 2);
        pushByte(8'h0C);
        repeat (8) tick();
        pushByte(8'h71);
        pushByte(8'h71);
        check("mid_clear_we", int'(ram_write_en), 1);
        check("mid_clear_busy", int'(busy), 1);
        rstn = 1'b0;
        tick();
        check("abort_we", int'(ram_write_en), 0);
        check("abort_cursor", int'(cursor), BASE);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(in_ready), 0);
        rstn = 1'b1;
        wq.delete();
        tick();
        check("abort_ready_after", int'(in_ready), 1);
        check("abort_fifo_empty", int'(busy), 0);
        repeat (10) tick();
        check("abort_no_writes", wq.size(), 0);
        check("abort_cursor_after", int'(cursor), BASE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
